// File: rtl/joy_serial_reader.sv
// Scans a daisy-chained 74HC165-style button register and deserialises PLAYERS x BITS buttons.
// Adds per-player presence detection and a two-frame debounce before committing a frame.
module joy_serial_reader #(
  parameter int unsigned PLAYERS = 2,
  parameter int unsigned BITS    = 12,
  parameter int unsigned DIV     = 24,
  parameter int unsigned GAP     = 16,
  parameter bit          INVERT  = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      joy_data,
  output logic                      joy_clk,
  output logic                      joy_load,
  output logic [PLAYERS*BITS-1:0]   joystick,
  output logic [PLAYERS-1:0]        present,
  output logic                      frame_stb
);

  localparam int unsigned TOTAL = PLAYERS * BITS;
  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned BIT_W = $clog2(TOTAL);
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_div;
  logic               w_tick;
  logic [1:0]         r_sync;
  logic               r_phase_l, w_phase_l_nxt;
  logic [BIT_W-1:0]   r_bit, w_bit_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic               w_clk_nxt, w_load_nxt, w_sample;
  logic [TOTAL-1:0]   r_raw;
  logic               r_done;
  logic               r_ref_valid;
  logic [TOTAL-1:0]   r_ref_word;
  logic [PLAYERS-1:0] r_ref_pres;
  logic [TOTAL-1:0]   w_word;
  logic [PLAYERS-1:0] w_pres;

  assign w_tick = (r_div == DIV_W'(DIV - 1));

  // Tick divider; restarts whenever the scanner drops back to IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (w_tick || (w_state_nxt == S_IDLE && r_state != S_IDLE)) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      joy_clk   <= 1'b1;
      joy_load  <= 1'b1;
      r_phase_l <= 1'b0;
      r_bit     <= '0;
      r_gap     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      joy_clk   <= w_clk_nxt;
      joy_load  <= w_load_nxt;
      r_phase_l <= w_phase_l_nxt;
      r_bit     <= w_bit_nxt;
      r_gap     <= w_gap_nxt;
    end
  end

  // Every strobe change happens on a tick; a low enable forces IDLE with both strobes high
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_nxt     = joy_clk;
    w_load_nxt    = joy_load;
    w_phase_l_nxt = r_phase_l;
    w_bit_nxt     = r_bit;
    w_gap_nxt     = r_gap;
    w_sample      = 1'b0;
    if (w_tick) begin
      if (!enable) begin
        w_state_nxt = S_IDLE;
        w_clk_nxt   = 1'b1;
        w_load_nxt  = 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            w_state_nxt = S_LOAD;
            w_load_nxt  = 1'b0;
          end
          S_LOAD: begin
            w_state_nxt   = S_SHIFT;
            w_load_nxt    = 1'b1;
            w_phase_l_nxt = 1'b0;
            w_bit_nxt     = '0;
          end
          S_SHIFT: begin
            if (!r_phase_l) begin
              w_sample = 1'b1;
              if (r_bit == BIT_W'(TOTAL - 1)) begin
                w_state_nxt = S_GAP;
                w_gap_nxt   = '0;
              end else begin
                w_phase_l_nxt = 1'b1;
                w_clk_nxt     = 1'b0;
              end
            end else begin
              w_phase_l_nxt = 1'b0;
              w_clk_nxt     = 1'b1;
              w_bit_nxt     = r_bit + BIT_W'(1);
            end
          end
          S_GAP: begin
            if (r_gap == GAP_W'(GAP - 1)) begin
              w_state_nxt = S_LOAD;
              w_load_nxt  = 1'b0;
            end else begin
              w_gap_nxt = r_gap + GAP_W'(1);
            end
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_raw  <= '0;
      r_done <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], joy_data};
      r_done <= w_sample && (w_state_nxt == S_GAP);
      if (w_sample) begin
        r_raw[r_bit] <= r_sync[1];
      end
    end
  end

  // An all-zero raw field means no controller is plugged in at that position
  always_comb begin
    w_word = '0;
    w_pres = '0;
    for (int unsigned p = 0; p < PLAYERS; p++) begin
      w_pres[p] = |r_raw[p*BITS +: BITS];
      if (w_pres[p]) begin
        w_word[p*BITS +: BITS] = r_raw[p*BITS +: BITS] ^ {BITS{INVERT}};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joystick    <= '0;
      present     <= '0;
      frame_stb   <= 1'b0;
      r_ref_valid <= 1'b0;
      r_ref_word  <= '0;
      r_ref_pres  <= '0;
    end else begin
      frame_stb <= 1'b0;
      if (!enable) begin
        r_ref_valid <= 1'b0;
      end else if (r_done) begin
        r_ref_word  <= w_word;
        r_ref_pres  <= w_pres;
        r_ref_valid <= 1'b1;
        if (r_ref_valid && (w_word == r_ref_word) && (w_pres == r_ref_pres)) begin
          joystick  <= w_word;
          present   <= w_pres;
          frame_stb <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_joy_serial_reader.sv
// Bench for joy_serial_reader: 74HC165 chain models drive two instances (defaults and a
// 4x8 non-inverted sweep); a scoreboard predicts every commit from the pins at each LOAD.
module tb_joy_serial_reader;

  typedef struct packed {
    logic [31:0] joy;
    logic [3:0]  pres;
    logic        inst;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  en;
  logic [1:0]  data;
  logic [1:0]  jclk;
  logic [1:0]  jload;
  logic [1:0]  stb;
  logic [23:0] joy_a;
  logic [1:0]  pres_a;
  logic [31:0] joy_b;
  logic [3:0]  pres_b;
  logic [31:0] pins  [2];
  logic [31:0] chain [2];

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb[$];
  exp_t ref_e [2];
  bit   refv  [2] = '{1'b0, 1'b0};
  logic ld_d  [2] = '{1'b1, 1'b1};
  logic en_d  [2] = '{1'b0, 1'b0};
  int   lat   [2] = '{0, 0};

  joy_serial_reader u_dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en[0]), .joy_data(data[0]),
    .joy_clk(jclk[0]), .joy_load(jload[0]), .joystick(joy_a), .present(pres_a),
    .frame_stb(stb[0])
  );

  // DIV=3 is the smallest divider that leaves the synchroniser three settled cycles per bit
  joy_serial_reader #(.PLAYERS(4), .BITS(8), .DIV(3), .GAP(4), .INVERT(1'b0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en[1]), .joy_data(data[1]),
    .joy_clk(jclk[1]), .joy_load(jload[1]), .joystick(joy_b), .present(pres_b),
    .frame_stb(stb[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge jclk[0] or negedge jload[0])
    if (!jload[0]) chain[0] <= pins[0];
    else           chain[0] <= chain[0] >> 1;

  always @(posedge jclk[1] or negedge jload[1])
    if (!jload[1]) chain[1] <= pins[1];
    else           chain[1] <= chain[1] >> 1;

  assign data[0] = chain[0][0];
  assign data[1] = chain[1][0];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic int tot(input int s);
    return (s != 0) ? 32 : 24;
  endfunction

  function automatic int dv(input int s);
    return (s != 0) ? 3 : 24;
  endfunction

  function automatic exp_t model(input int s, input logic [31:0] p);
    exp_t        e;
    int          np, nb;
    bit          inv;
    logic [15:0] raw, msk;
    np  = (s != 0) ? 4 : 2;
    nb  = (s != 0) ? 8 : 12;
    inv = (s == 0);
    msk = 16'((32'd1 << nb) - 32'd1);
    e = '0;
    e.inst = 1'(s);
    for (int k = 0; k < np; k++) begin
      raw = 16'(p >> (k * nb)) & msk;
      if (raw != 16'h0) begin
        e.pres[k] = 1'b1;
        e.joy = e.joy | (32'(inv ? (~raw & msk) : raw) << (k * nb));
      end
    end
    return e;
  endfunction

  function automatic exp_t observe(input int s);
    exp_t o;
    o = '0;
    o.inst = 1'(s);
    if (s == 0) begin
      o.joy  = 32'(joy_a);
      o.pres = 4'(pres_a);
    end else begin
      o.joy  = joy_b;
      o.pres = pres_b;
    end
    return o;
  endfunction

  // Scoreboard: predict at each LOAD, compare at each frame_stb
  always @(negedge clk) begin
    exp_t e, o;
    if (!reset_n) sb.delete();
    for (int s = 0; s < 2; s++) begin
      if (en_d[s] && !en[s]) sb.delete();
      if (!reset_n || !en[s]) refv[s] = 1'b0;
      lat[s] = lat[s] + 1;
      if (reset_n && en[s] && ld_d[s] && !jload[s]) begin
        e = model(s, pins[s]);
        if (refv[s] && e == ref_e[s]) sb.push_back(e);
        ref_e[s] = e;
        refv[s]  = 1'b1;
        lat[s]   = 0;
      end
      if (stb[s]) begin
        o = observe(s);
        chk("stb_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("stb_inst", 64'(e.inst), 64'(s));
          chk("commit_joy", 64'(o.joy), 64'(e.joy));
          chk("commit_pres", 64'(o.pres), 64'(e.pres));
          chk("commit_latency", 64'(lat[s]), 64'(2 * tot(s) * dv(s) + 1));
        end
      end
      ld_d[s] = jload[s];
      en_d[s] = en[s];
    end
  end

  task automatic wait_ld(input int s, input logic lvl);
    for (int i = 0; i < 4000 && jload[s] !== lvl; i++) @(negedge clk);
    chk("wait_load", 64'(jload[s]), 64'(lvl));
  endtask

  task automatic frames(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      wait_ld(s, 1'b0);
      wait_ld(s, 1'b1);
    end
  endtask

  initial begin
    int n;
    logic prev;
    reset_n = 1'b0;
    en      = 2'b00;
    pins[0] = 32'h00FF_FFFE;
    pins[1] = 32'h5A00_8001;
    repeat (3) @(negedge clk);
    chk("rst_joy_clk", 64'(jclk[0]), 64'd1);
    chk("rst_joy_load", 64'(jload[0]), 64'd1);
    chk("rst_joystick", 64'(joy_a), 64'd0);
    chk("rst_present", 64'(pres_a), 64'd0);
    chk("rst_stb", 64'(stb[0]), 64'd0);
    chk("rst_b_load", 64'(jload[1]), 64'd1);
    chk("rst_b_joystick", 64'(joy_b), 64'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Stable input: first LOAD within one tick of enable, commits from frame 2 on
    en[0] = 1'b1;
    n = 0;
    while (jload[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_load_within_tick", 64'(n <= 25), 64'd1);
    frames(0, 4);
    chk("stable_joy", 64'(joy_a), 64'h00_0001);
    chk("stable_pres", 64'(pres_a), 64'b11);

    // Strobe timing over one frame
    n = 0;
    prev = jclk[0];
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!jload[0]) break;
      if (prev && !jclk[0]) n++;
      prev = jclk[0];
    end
    chk("joy_clk_lows", 64'(n), 64'd23);
    n = 0;
    while (!jload[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("load_low_width", 64'(n), 64'd24);
    for (int i = 0; i < 3000 && !stb[0]; i++) @(negedge clk);
    chk("stb_seen", 64'(stb[0]), 64'd1);
    n = 0;
    while (jload[0] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("gap_to_load", 64'(n), 64'(16 * 24 - 1));
    wait_ld(0, 1'b1);

    // Debounce: toggling pattern never commits, held pattern commits two frames later
    for (int k = 0; k < 4; k++) begin
      pins[0] = (k % 2 == 0) ? 32'h00FF_FFFD : 32'h00FF_FFFE;
      frames(0, 1);
    end
    chk("toggle_joy_held", 64'(joy_a), 64'h00_0001);
    pins[0] = 32'h00FF_FFFD;
    frames(0, 3);
    chk("debounce_commit", 64'(joy_a), 64'h00_0002);

    // Presence: player 1 unplugged
    pins[0] = 32'h0000_0FFE;
    frames(0, 3);
    chk("presence_joy", 64'(joy_a), 64'h00_0001);
    chk("presence_pres", 64'(pres_a), 64'b01);
    chk("sb_depth", 64'(sb.size()), 64'd1);

    // Abort mid-SHIFT, then re-enable with a new pattern
    repeat (200) @(negedge clk);
    en[0] = 1'b0;
    repeat (24) @(negedge clk);
    chk("abort_clk_high", 64'(jclk[0]), 64'd1);
    chk("abort_load_high", 64'(jload[0]), 64'd1);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (!jclk[0] || !jload[0]) n++;
    end
    chk("abort_strobes_idle", 64'(n), 64'd0);
    chk("abort_joy_kept", 64'(joy_a), 64'h00_0001);
    chk("abort_pres_kept", 64'(pres_a), 64'b01);
    pins[0] = 32'h00FF_FFFB;
    en[0] = 1'b1;
    frames(0, 3);
    chk("reenable_joy", 64'(joy_a), 64'h00_0004);
    chk("reenable_pres", 64'(pres_a), 64'b11);

    // Asynchronous reset in the low half of a shift bit
    repeat (30) @(negedge clk);
    chk("pre_reset_clk_low", 64'(jclk[0]), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_joy_clk", 64'(jclk[0]), 64'd1);
    chk("arst_joy_load", 64'(jload[0]), 64'd1);
    chk("arst_joystick", 64'(joy_a), 64'd0);
    chk("arst_present", 64'(pres_a), 64'd0);
    chk("arst_stb", 64'(stb[0]), 64'd0);
    en[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Parameter sweep: 4 players x 8 bits, active-high pins, player 2 absent
    en[1] = 1'b1;
    frames(1, 4);
    chk("sweep_joy", 64'(joy_b), 64'h5A00_8001);
    chk("sweep_pres", 64'(pres_b), 64'b1011);
    for (int i = 0; i < 500 && !stb[1]; i++) @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    en[1] = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
